// File: rtl/msec_alarm_pkg.sv
// Shared definitions for the millisecond alarm peripheral: register map, CTRL layout, FSM encoding.
package msec_alarm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] REG_NOW    = 3'd0;
  localparam logic [ADDR_W-1:0] REG_CMP    = 3'd1;
  localparam logic [ADDR_W-1:0] REG_PERIOD = 3'd2;
  localparam logic [ADDR_W-1:0] REG_CTRL   = 3'd3;
  localparam logic [ADDR_W-1:0] REG_STATUS = 3'd4;

  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_PERIODIC_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 2;

  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic en;
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_e;

  // Wrap-safe deadline test: signed difference now - cmp is non-negative.
  function automatic logic is_due(input logic [DATA_W-1:0] now, input logic [DATA_W-1:0] cmp);
    logic [DATA_W-1:0] diff;
    diff = now - cmp;
    return ~diff[DATA_W-1];
  endfunction

endpackage

// File: rtl/msec_alarm_regs.sv
// Bus decode, registered ack/rdata and register file for msec_alarm.
// Overrun counter is present only when MSEC_ALARM_OVERRUN_EN is defined.
module msec_alarm_regs
  import msec_alarm_pkg::*;
#(
`ifdef MSEC_ALARM_OVERRUN_EN
  parameter int unsigned OVR_W = 8,
`endif
  parameter logic [DATA_W-1:0] CMP_RESET = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] msec_elapsed,
  input  logic              bus_sel,
  input  logic              bus_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ack,
  input  logic              fire_c,
  input  logic              reload_c,
  output logic [DATA_W-1:0] cmp,
  output logic [DATA_W-1:0] period,
  output ctrl_t             ctrl,
  output logic              fired,
  output logic              ctrl_wr_c,
  output logic              ctrl_wen_c
);

  logic wr_c;
  logic cmp_wr_c;
  logic period_wr_c;
  logic status_wr_c;
  logic [DATA_W-1:0] status_c;
  logic [DATA_W-1:0] rd_mux_c;

  assign wr_c        = bus_sel & bus_wr;
  assign cmp_wr_c    = wr_c && (bus_addr == REG_CMP);
  assign period_wr_c = wr_c && (bus_addr == REG_PERIOD);
  assign ctrl_wr_c   = wr_c && (bus_addr == REG_CTRL);
  assign status_wr_c = wr_c && (bus_addr == REG_STATUS);
  assign ctrl_wen_c  = bus_wdata[CTRL_EN_BIT];

  // A bus write to CMP takes priority over the periodic reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp <= CMP_RESET;
    end else if (cmp_wr_c) begin
      cmp <= bus_wdata;
    end else if (fire_c && reload_c) begin
      cmp <= cmp + period;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period <= '0;
      ctrl   <= '0;
    end else begin
      if (period_wr_c) period <= bus_wdata;
      if (ctrl_wr_c) begin
        ctrl.en       <= bus_wdata[CTRL_EN_BIT];
        ctrl.periodic <= bus_wdata[CTRL_PERIODIC_BIT];
        ctrl.irq_en   <= bus_wdata[CTRL_IRQ_EN_BIT];
      end
    end
  end

  // Setting by a fire wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fired <= 1'b0;
    end else if (fire_c) begin
      fired <= 1'b1;
    end else if (status_wr_c && bus_wdata[0]) begin
      fired <= 1'b0;
    end
  end

`ifdef MSEC_ALARM_OVERRUN_EN
  localparam logic [OVR_W-1:0] OVR_MAX = '1;
  logic [OVR_W-1:0] overrun;

  // A STATUS write on a fire cycle leaves the count untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= '0;
    end else if (status_wr_c) begin
      if (!fire_c) overrun <= '0;
    end else if (fire_c && fired && (overrun != OVR_MAX)) begin
      overrun <= overrun + OVR_W'(1);
    end
  end
`endif

  always_comb begin
    status_c    = '0;
    status_c[0] = fired;
`ifdef MSEC_ALARM_OVERRUN_EN
    status_c[8 +: OVR_W] = overrun;
`endif
  end

  always_comb begin
    rd_mux_c = '0;
    case (bus_addr)
      REG_NOW:    rd_mux_c = msec_elapsed;
      REG_CMP:    rd_mux_c = cmp;
      REG_PERIOD: rd_mux_c = period;
      REG_CTRL:   rd_mux_c = DATA_W'(ctrl);
      REG_STATUS: rd_mux_c = status_c;
      default:    rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack   <= bus_sel;
      bus_rdata <= (bus_sel && !bus_wr) ? rd_mux_c : '0;
    end
  end

endmodule

// File: rtl/msec_alarm.sv
// Millisecond alarm/compare peripheral: one-shot or periodic deadlines with level interrupt.
// Define MSEC_ALARM_OVERRUN_EN to include the saturating overrun counter in STATUS.
module msec_alarm
  import msec_alarm_pkg::*;
#(
  parameter int unsigned       OVR_W     = 8,
  parameter logic [DATA_W-1:0] CMP_RESET = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] msec_elapsed,
  input  logic              bus_sel,
  input  logic              bus_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_ack,
  output logic              irq
);

  if ((OVR_W < 1) || (OVR_W > 24)) begin : g_ovr_w_check
    $error("msec_alarm: OVR_W must fit in STATUS[31:8]");
  end

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] cmp;
  logic [DATA_W-1:0] period;
  ctrl_t             ctrl;
  logic              fired;
  logic              ctrl_wr_c;
  logic              ctrl_wen_c;
  logic              fire_c;
  logic              reload_c;

  msec_alarm_regs #(
`ifdef MSEC_ALARM_OVERRUN_EN
    .OVR_W     (OVR_W),
`endif
    .CMP_RESET (CMP_RESET)
  ) u_regs (
    .clk          (clk),
    .reset        (reset),
    .msec_elapsed (msec_elapsed),
    .bus_sel      (bus_sel),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .fire_c       (fire_c),
    .reload_c     (reload_c),
    .cmp          (cmp),
    .period       (period),
    .ctrl         (ctrl),
    .fired        (fired),
    .ctrl_wr_c    (ctrl_wr_c),
    .ctrl_wen_c   (ctrl_wen_c)
  );

  assign fire_c   = (state_q == ARMED) && ctrl.en && is_due(msec_elapsed, cmp);
  assign reload_c = ctrl.periodic && (period != '0);
  assign irq      = fired & ctrl.irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A CTRL write overrides any fire-driven transition in the same cycle.
  always_comb begin
    state_d = state_q;
    if (ctrl_wr_c) begin
      state_d = ctrl_wen_c ? ARMED : IDLE;
    end else if (fire_c && !reload_c) begin
      state_d = FIRED;
    end
  end

endmodule

// File: tb/tb_msec_alarm.sv
// Directed self-checking bench for msec_alarm (default and MSEC_ALARM_OVERRUN_EN builds).
module tb_msec_alarm;
  import msec_alarm_pkg::*;

`ifdef MSEC_ALARM_OVERRUN_EN
  localparam logic [31:0] OVR_SAT = 32'h0000_FF00;
`else
  localparam logic [31:0] OVR_SAT = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] msec_elapsed;
  logic        bus_sel;
  logic        bus_wr;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        irq;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  msec_alarm dut (
    .clk          (clk),
    .reset        (reset),
    .msec_elapsed (msec_elapsed),
    .bus_sel      (bus_sel),
    .bus_wr       (bus_wr),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .irq          (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = addr; bus_wdata = data;
    tick();
    bus_sel = 1'b0; bus_wr = 1'b0; bus_wdata = '0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = addr;
    tick();
    bus_sel = 1'b0;
    check("rd_ack", 32'(bus_ack), 32'd1);
    data = bus_rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; msec_elapsed = '0; bus_sel = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
    repeat (2) tick();
    check("reset_ack", 32'(bus_ack), 32'd0);
    check("reset_rdata", bus_rdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    tick();

    // Read handshake: ack one cycle after sel, rdata valid only then
    msec_elapsed = 32'd1234;
    bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = REG_NOW;
    check("ack_in_sel_cycle", 32'(bus_ack), 32'd0);
    tick();
    bus_sel = 1'b0;
    check("now_ack", 32'(bus_ack), 32'd1);
    check("now_rdata", bus_rdata, 32'd1234);
    tick();
    check("ack_drops", 32'(bus_ack), 32'd0);
    check("rdata_zero_after_ack", bus_rdata, 32'd0);
    bus_read(REG_CTRL, rd);   check("ctrl_reset", rd, 32'd0);
    bus_read(REG_CMP, rd);    check("cmp_reset", rd, 32'hFFFF_FFFF);
    bus_read(REG_STATUS, rd); check("status_reset", rd, 32'd0);

    // One-shot at 100
    msec_elapsed = 32'd98;
    bus_write(REG_CMP, 32'd100);
    bus_write(REG_CTRL, 32'h5);
    tick(); check("oneshot_98", 32'(irq), 32'd0);
    msec_elapsed = 32'd99;  tick(); check("oneshot_99", 32'(irq), 32'd0);
    msec_elapsed = 32'd100; tick(); check("oneshot_100", 32'(irq), 32'd1);
    bus_read(REG_STATUS, rd); check("oneshot_status", rd, 32'd1);
    bus_write(REG_STATUS, 32'd1);
    check("oneshot_w1c_irq", 32'(irq), 32'd0);
    msec_elapsed = 32'd101;
    repeat (3) tick();
    check("fired_no_recompare", 32'(irq), 32'd0);

    // Periodic across the 2^32 wrap; W1C every cycle turns irq into a per-cycle fire flag
    bus_write(REG_CTRL, 32'h0);
    msec_elapsed = 32'hFFFF_FFF0;
    bus_write(REG_CMP, 32'hFFFF_FFFE);
    bus_write(REG_PERIOD, 32'd5);
    bus_write(REG_CTRL, 32'h7);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] m;
      m = 32'hFFFF_FFFE + 32'(i);
      msec_elapsed = m;
      bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = REG_STATUS; bus_wdata = 32'd1;
      tick();
      check($sformatf("wrap_fire_%h", m), 32'(irq),
            ((m == 32'hFFFF_FFFE) || (m == 32'd3)) ? 32'd1 : 32'd0);
    end
    bus_sel = 1'b0; bus_wr = 1'b0; bus_wdata = '0;
    bus_read(REG_CMP, rd); check("wrap_cmp", rd, 32'd8);

    // CMP write collides with periodic fire: bus value wins, fired still set
    msec_elapsed = 32'd8;
    bus_write(REG_CMP, 32'd50);
    check("cmp_collide_irq", 32'(irq), 32'd1);
    bus_read(REG_CMP, rd); check("cmp_collide_val", rd, 32'd50);

    // W1C collides with fire: fired stays set
    msec_elapsed = 32'd50;
    bus_write(REG_STATUS, 32'd1);
    check("w1c_collide_irq", 32'(irq), 32'd1);
    bus_read(REG_STATUS, rd); check("w1c_collide_status", rd, 32'd1);
    bus_write(REG_STATUS, 32'd1);
    check("w1c_clear", 32'(irq), 32'd0);

    // CTRL en=0 collides with fire: fired set, then idle
    msec_elapsed = 32'd55;
    bus_write(REG_CTRL, 32'h4);
    check("ctrl_off_collide_irq", 32'(irq), 32'd1);
    bus_write(REG_STATUS, 32'd1);
    msec_elapsed = 32'd60;
    repeat (3) tick();
    check("idle_no_fire", 32'(irq), 32'd0);
    bus_read(REG_CTRL, rd); check("ctrl_readback", rd, 32'd4);

    // Overrun: fire every ms for 300 ms with no clearing
    msec_elapsed = 32'd100;
    bus_write(REG_STATUS, 32'd0);
    bus_write(REG_CMP, 32'd101);
    bus_write(REG_PERIOD, 32'd1);
    bus_write(REG_CTRL, 32'h7);
    for (int i = 0; i < 300; i++) begin
      msec_elapsed = 32'd101 + 32'(i);
      tick();
    end
    bus_read(REG_STATUS, rd); check("overrun_sat", rd, OVR_SAT | 32'd1);
    msec_elapsed = 32'd401;
    bus_write(REG_STATUS, 32'd1);
    bus_read(REG_STATUS, rd); check("overrun_w1c_on_fire", rd, OVR_SAT | 32'd1);
    bus_write(REG_STATUS, 32'd0);
    bus_read(REG_STATUS, rd); check("overrun_cleared", rd, 32'd1);

    // Async reset between edges with a request pending
    bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = REG_NOW;
    tick();
    check("pre_reset_ack", 32'(bus_ack), 32'd1);
    check("pre_reset_rdata", bus_rdata, 32'd401);
    check("pre_reset_irq", 32'(irq), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_ack", 32'(bus_ack), 32'd0);
    check("async_rdata", bus_rdata, 32'd0);
    check("async_irq", 32'(irq), 32'd0);
    bus_sel = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("no_ack_after_reset", 32'(bus_ack), 32'd0);
    bus_read(REG_CTRL, rd);   check("post_reset_ctrl", rd, 32'd0);
    bus_read(REG_CMP, rd);    check("post_reset_cmp", rd, 32'hFFFF_FFFF);
    bus_read(REG_STATUS, rd); check("post_reset_status", rd, 32'd0);
    bus_read(REG_PERIOD, rd); check("post_reset_period", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
